// File: rtl/aes128_dec_iter_if.sv
// Request/result handshake bundle for the iterative AES-128 decrypt core.
// The master side supplies jobs and consumes results; the slave side is the core.
interface aes128_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_i;
    logic [127:0] key10_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_o;
    logic [127:0] key0_o;

    modport master (
        output in_valid, ct_i, key10_i, out_ready,
        input  in_ready, out_valid, pt_o, key0_o
    );

    modport slave (
        input  in_valid, ct_i, key10_i, out_ready,
        output in_ready, out_valid, pt_o, key0_o
    );
endinterface

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, with the key schedule
// walked backwards from the round-10 key so that no round keys are stored.
module aes128_dec_iter #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input logic              clk,
    input logic              rst,
    aes128_dec_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       state_reg;
    logic [127:0] st_reg;
    logic [127:0] rk_reg;
    logic [3:0]   rnd_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = gmul(a, a);
        r = p;
        for (int i = 0; i < 6; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Inverse key step: recover round key (rnd-1) from round key rnd.
    logic [31:0]  r0, r1, r2, r3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [7:0]   rcon;
    logic [127:0] p_key;
    logic [127:0] t_st;
    logic [127:0] m_st;

    assign r0    = rk_reg[127:96];
    assign r1    = rk_reg[95:64];
    assign r2    = rk_reg[63:32];
    assign r3    = rk_reg[31:0];
    assign p3    = r3 ^ r2;
    assign p2    = r2 ^ r1;
    assign p1    = r1 ^ r0;
    assign rot_w = {p3[23:0], p3[31:24]};
    assign p0    = r0 ^ sub_w ^ {rcon, 24'h000000};
    assign p_key = {p0, p1, p2, p3};

    always_comb begin
        rcon = 8'h00;
        case (rnd_reg)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_w[8*gi +: 8] = sbox(rot_w[8*gi +: 8]);
        end

        // Byte gi sits at row gi%4, column gi/4; inverse shift moves row r right by r.
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
            assign t_st[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]) ^ p_key[127-8*gi -: 8];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = t_st[127-32*gi -: 8];
            assign a1 = t_st[119-32*gi -: 8];
            assign a2 = t_st[111-32*gi -: 8];
            assign a3 = t_st[103-32*gi -: 8];
            assign m_st[127-32*gi -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
            };
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            st_reg        <= '0;
            rk_reg        <= '0;
            rnd_reg       <= 4'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        st_reg       <= bus.ct_i ^ bus.key10_i;
                        rk_reg       <= bus.key10_i;
                        rnd_reg      <= 4'd10;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ROUND;
                    end
                end
                ROUND: begin
                    // The final round omits InvMixColumns.
                    st_reg  <= (rnd_reg != 4'd1) ? m_st : t_st;
                    rk_reg  <= p_key;
                    rnd_reg <= rnd_reg - 4'd1;
                    if (rnd_reg == 4'd1) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                        if (CLEAR_ON_DONE) begin
                            st_reg <= '0;
                            rk_reg <= '0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    // Outputs are masked outside DONE so intermediate state never reaches the pins.
    assign bus.pt_o      = (CLEAR_ON_DONE && !out_valid_reg) ? '0 : st_reg;
    assign bus.key0_o    = (CLEAR_ON_DONE && !out_valid_reg) ? '0 : rk_reg;
endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed bench for aes128_dec_iter: FIPS-197 vectors, latency, backpressure,
// mid-run reset, back-to-back jobs and register clearing with both parameter settings.
module tb_aes128_dec_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    aes128_dec_iter_if bus ();
    aes128_dec_iter_if bus_k ();

    aes128_dec_iter #(.CLEAR_ON_DONE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    aes128_dec_iter #(.CLEAR_ON_DONE(1'b0)) dut_keep (.clk(clk), .rst(rst), .bus(bus_k));

    // The retaining instance runs in lockstep on identical stimulus.
    assign bus_k.in_valid  = bus.in_valid;
    assign bus_k.ct_i      = bus.ct_i;
    assign bus_k.key10_i   = bus.key10_i;
    assign bus_k.out_ready = bus.out_ready;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] k0;
    } vec_t;

    vec_t vecs [2];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents a job and returns at the falling edge of the first ROUND cycle.
    task automatic send(input logic [127:0] ct, input logic [127:0] key, input bit hold);
        int n;
        n = 0;
        bus.ct_i     = ct;
        bus.key10_i  = key;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 128'(n < 100), 128'(1));
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("out_timeout", 128'(lat < 100), 128'(1));
    endtask

    task automatic check_result(input string nm, input int idx, input int lat);
        check({nm, "_latency"}, 128'(lat), 128'(11));
        check({nm, "_out_valid"}, 128'(bus.out_valid), 128'(1));
        check({nm, "_pt"}, bus.pt_o, vecs[idx].pt);
        check({nm, "_key0"}, bus.key0_o, vecs[idx].k0);
        check({nm, "_keep_pt"}, bus_k.pt_o, vecs[idx].pt);
        $display("job %s: lat=%0d pt=%h key0=%h", nm, lat, bus.pt_o, bus.key0_o);
    endtask

    // Single job with out_ready high, followed by clear/retain checks.
    task automatic run_vec(input string nm, input int idx);
        int lat;
        bus.out_ready = 1'b1;
        send(vecs[idx].ct, vecs[idx].key, 1'b0);
        wait_out(lat);
        check_result(nm, idx, lat);
        @(negedge clk);
        check({nm, "_post_valid"}, 128'(bus.out_valid), 128'(0));
        check({nm, "_post_ready"}, 128'(bus.in_ready), 128'(1));
        check({nm, "_post_pt"}, bus.pt_o, 128'(0));
        check({nm, "_post_key0"}, bus.key0_o, 128'(0));
        check({nm, "_clr_st"}, dut.st_reg, 128'(0));
        check({nm, "_clr_rk"}, dut.rk_reg, 128'(0));
        check({nm, "_keep_st"}, dut_keep.st_reg, vecs[idx].pt);
        check({nm, "_keep_rk"}, dut_keep.rk_reg, vecs[idx].k0);
    endtask

    initial begin
        int lat;
        bit seen;
        vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                    128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c};

        bus.in_valid  = 1'b0;
        bus.ct_i      = '0;
        bus.key10_i   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_pt", bus.pt_o, 128'(0));
        check("rst_key0", bus.key0_o, 128'(0));

        run_vec("c1", 0);
        run_vec("appb", 1);

        // Back-to-back: in_valid held, second accept in the IDLE cycle after the handshake.
        send(vecs[0].ct, vecs[0].key, 1'b1);
        bus.ct_i    = vecs[1].ct;
        bus.key10_i = vecs[1].key;
        wait_out(lat);
        check_result("b2b_first", 0, lat);
        @(negedge clk);
        check("b2b_bubble_ready", 128'(bus.in_ready), 128'(1));
        check("b2b_bubble_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        check("b2b_second_accepted", 128'(bus.in_ready), 128'(0));
        bus.in_valid = 1'b0;
        wait_out(lat);
        check_result("b2b_second", 1, lat);
        @(negedge clk);

        // Backpressure: result held for 20 cycles while a second job waits.
        bus.out_ready = 1'b0;
        send(vecs[0].ct, vecs[0].key, 1'b1);
        bus.ct_i    = vecs[1].ct;
        bus.key10_i = vecs[1].key;
        wait_out(lat);
        check_result("bp_first", 0, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(bus.out_valid), 128'(1));
            check("bp_hold_pt", bus.pt_o, vecs[0].pt);
            check("bp_hold_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 128'(bus.out_valid), 128'(0));
        check("bp_release_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        check("bp_second_accepted", 128'(bus.in_ready), 128'(0));
        bus.in_valid = 1'b0;
        wait_out(lat);
        check_result("bp_second", 1, lat);
        @(negedge clk);

        // Reset during the 5th ROUND cycle discards the job.
        send(vecs[0].ct, vecs[0].key, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_pt", bus.pt_o, 128'(0));
        check("midrst_key0", bus.key0_o, 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        run_vec("post_rst_appb", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
